hyperram_arbiter: RTL



---
 rtl/hyperram_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hyperram_arbiter.sv
// Two-port round-robin arbiter in front of the HyperRAM controller request interface.
// It runs one transaction at a time, steers read beats to the owning port and flags protocol faults.
module hyperram_arbiter #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_wr,
    input  logic        p0_mem_or_reg,
    input  logic [3:0]  p0_byte_en,
    input  logic [5:0]  p0_num_dwords,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wr_d,
    output logic        p0_gnt,
    output logic [31:0] p0_rd_d,
    output logic        p0_rd_vld,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_wr,
    input  logic        p1_mem_or_reg,
    input  logic [3:0]  p1_byte_en,
    input  logic [5:0]  p1_num_dwords,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wr_d,
    output logic        p1_gnt,
    output logic [31:0] p1_rd_d,
    output logic        p1_rd_vld,
    output logic        p1_done,
    output logic        p1_err,
    output logic        xf_rd_req,
    output logic        xf_wr_req,
    output logic        xf_mem_or_reg,
    output logic [3:0]  xf_wr_byte_en,
    output logic [5:0]  xf_rd_num_dwords,
    output logic [31:0] xf_addr,
    output logic [31:0] xf_wr_d,
    input  logic [31:0] xf_rd_d,
    input  logic        xf_rd_rdy,
    input  logic        xf_busy
);

    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t state, next_state;

    logic        owner, last_owner, grant_port;
    logic        do_latch, finish, finish_err, beat;
    logic        sel_wr, sel_mor;
    logic [3:0]  sel_be;
    logic [5:0]  sel_nd;
    logic [31:0] sel_addr, sel_wd;
    logic        cmd_wr, cmd_mor;
    logic [3:0]  cmd_be;
    logic [5:0]  cmd_nd;
    logic [31:0] cmd_addr, cmd_wd;
    logic [6:0]  beat_cnt, beat_final;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]  rd_vld_q, done_q, err_q;
    logic [31:0] p0_rd_q, p1_rd_q;
    logic        active, issue;

    // On a tie the port that did not own the previous transaction wins.
    always_comb begin
        grant_port = (p0_req && p1_req) ? ~last_owner : p1_req;
        sel_wr     = grant_port ? p1_wr         : p0_wr;
        sel_mor    = grant_port ? p1_mem_or_reg : p0_mem_or_reg;
        sel_be     = grant_port ? p1_byte_en    : p0_byte_en;
        sel_addr   = grant_port ? p1_addr       : p0_addr;
        sel_wd     = grant_port ? p1_wr_d       : p0_wr_d;
        sel_nd     = grant_port ? p1_num_dwords : p0_num_dwords;
        if (sel_nd == 6'd0) sel_nd = 6'd1;
    end

    assign beat_final = beat_cnt + 7'(beat);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        next_state = state;
        do_latch   = 1'b0;
        finish     = 1'b0;
        finish_err = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    next_state = ISSUE;
                    do_latch   = 1'b1;
                end
            end
            ISSUE: next_state = WAIT_ACK;
            WAIT_ACK: begin
                beat = xf_rd_rdy;
                if (xf_busy) begin
                    next_state = WAIT_DONE;
                end else if (to_cnt == TO_LAST) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            WAIT_DONE: begin
                beat = xf_rd_rdy;
                if (!xf_busy) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                    finish_err = cmd_wr ? (beat_final != 7'd0) : (beat_final != {1'b0, cmd_nd});
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            cmd_wr     <= 1'b0;
            cmd_mor    <= 1'b0;
            cmd_be     <= '0;
            cmd_nd     <= '0;
            cmd_addr   <= '0;
            cmd_wd     <= '0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
            rd_vld_q   <= '0;
            done_q     <= '0;
            err_q      <= '0;
            p0_rd_q    <= '0;
            p1_rd_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (do_latch) begin
                owner      <= grant_port;
                last_owner <= grant_port;
                cmd_wr     <= sel_wr;
                cmd_mor    <= sel_mor;
                cmd_be     <= sel_be;
                cmd_nd     <= sel_nd;
                cmd_addr   <= sel_addr;
                cmd_wd     <= sel_wd;
                beat_cnt   <= '0;
                to_cnt     <= '0;
            end else begin
                if (beat) beat_cnt <= beat_cnt + 7'd1;
                if (state == WAIT_ACK && !xf_busy) to_cnt <= to_cnt + TO_W'(1);
            end

            rd_vld_q <= '0;
            done_q   <= '0;
            err_q    <= '0;
            p0_rd_q  <= '0;
            p1_rd_q  <= '0;
            // Beats are forwarded only on reads; a beat on a write is counted to raise err.
            if (beat && !cmd_wr) begin
                rd_vld_q[owner] <= 1'b1;
                if (owner) p1_rd_q <= xf_rd_d;
                else       p0_rd_q <= xf_rd_d;
            end
            if (finish) begin
                done_q[owner] <= 1'b1;
                err_q[owner]  <= finish_err;
            end
        end
    end

    assign active = (state != IDLE);
    assign issue  = (state == ISSUE);

    assign p0_gnt    = issue && !owner;
    assign p1_gnt    = issue && owner;
    assign p0_rd_vld = rd_vld_q[0];
    assign p1_rd_vld = rd_vld_q[1];
    assign p0_done   = done_q[0];
    assign p1_done   = done_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rd_d   = p0_rd_q;
    assign p1_rd_d   = p1_rd_q;

    assign xf_wr_req        = issue && cmd_wr;
    assign xf_rd_req        = issue && !cmd_wr;
    assign xf_mem_or_reg    = active && cmd_mor;
    assign xf_wr_byte_en    = active ? cmd_be   : '0;
    assign xf_rd_num_dwords = active ? cmd_nd   : '0;
    assign xf_addr          = active ? cmd_addr : '0;
    assign xf_wr_d          = active ? cmd_wd   : '0;

endmodule
